// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and handshaked fetch sequencer for the multi-cycle MIPS-32 core
//
// Owns the PC, fetches one instruction at a time over a req/ready handshake,
// computes the next PC on retire (sequential, branch, J/JAL, JR), produces the
// JAL link write and traps on a misaligned jump target or a fetch timeout.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr    fetch request held until imem_ready; address is always pc
//   imem_ready/imem_rdata fetch response
//   instr/instr_valid     latched instruction awaiting retire
//   retire                execute done; pc_sel, branch_taken, branch_off,
//                         jump_idx, jr_target, link_en are valid this cycle
//   link_we/link_addr     one-cycle register-31 write of the return address
//   pc                    current program counter
//   trap/trap_cause/epc   one-cycle trap pulse; cause and epc hold until next trap
module pc_sequencer #(
  parameter int                 ADDR_W        = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR  = '0,
  parameter logic [ADDR_W-1:0]  TRAP_VECTOR   = ADDR_W'(32'h80),
  parameter int                 FETCH_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              retire,
  input  logic [1:0]        pc_sel,
  input  logic              branch_taken,
  input  logic [15:0]       branch_off,
  input  logic [25:0]       jump_idx,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              link_en,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [ADDR_W-1:0] epc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_TRAP  = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  // Timeout counter only needs to reach FETCH_TIMEOUT-1; a zero timeout
  // disables the counter entirely.
  localparam bit              TO_EN    = (FETCH_TIMEOUT > 0);
  localparam int              CNT_W    = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);

  state_t            state, next_state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [1:0]        pend_cause;   // cause latched on the way into TRAP

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] jmp_pc;
  logic [ADDR_W-1:0] target;
  logic              misaligned;
  logic              timeout_hit;

  // ---------------------------------------------------------------- next PC
  assign seq_pc = pc + ADDR_W'(4);
  assign br_off = {{(ADDR_W-18){branch_off[15]}}, branch_off, 2'b00};
  assign br_pc  = seq_pc + br_off;

  generate
    if (ADDR_W > 28) begin : g_jmp_upper
      assign jmp_pc = {seq_pc[ADDR_W-1:28], jump_idx, 2'b00};
    end else begin : g_jmp_flat
      assign jmp_pc = {jump_idx, 2'b00};
    end
  endgenerate

  always_comb begin
    target = seq_pc;
    case (pc_sel)
      2'd0:    target = seq_pc;
      2'd1:    target = branch_taken ? br_pc : seq_pc;
      2'd2:    target = jmp_pc;
      default: target = jr_target;
    endcase
  end

  // Only JR can produce a non-word-aligned target, but checking the
  // selected value covers every case uniformly.
  assign misaligned  = |target[1:0];
  assign timeout_hit = TO_EN && !imem_ready && (wait_cnt == CNT_LAST);

  // ------------------------------------------------------------ state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // ------------------------------------------------------------ next state
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: begin
        if (imem_ready) begin
          next_state = S_EXEC;
        end else if (timeout_hit) begin
          next_state = S_TRAP;
        end
      end
      S_EXEC: begin
        if (retire) begin
          next_state = misaligned ? S_TRAP : S_FETCH;
        end
      end
      default: next_state = S_FETCH;
    endcase
  end

  // ------------------------------------------------------------ outputs
  always_comb begin
    imem_req = 1'b0;
    trap     = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_TRAP:  trap     = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      instr       <= '0;
      instr_valid <= 1'b0;
      link_we     <= 1'b0;
      link_addr   <= '0;
      trap_cause  <= 2'b00;
      epc         <= '0;
      wait_cnt    <= '0;
      pend_cause  <= 2'b00;
    end else begin
      link_we <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            wait_cnt    <= '0;
          end else if (timeout_hit) begin
            wait_cnt   <= '0;
            pend_cause <= CAUSE_TIMEOUT;
          end else if (TO_EN) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (retire) begin
            instr_valid <= 1'b0;
            if (misaligned) begin
              // pc stays on the faulting instruction so TRAP can record it
              pend_cause <= CAUSE_MISALIGN;
            end else begin
              pc <= target;
              if (link_en && (pc_sel == 2'd2)) begin
                link_we   <= 1'b1;
                link_addr <= seq_pc;
              end
            end
          end
        end
        S_TRAP: begin
          epc         <= pc;
          trap_cause  <= pend_cause;
          pc          <= TRAP_VECTOR;
          instr_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  typedef struct packed {
    logic [1:0]  sel;
    logic        taken;
    logic [15:0] off;
    logic [25:0] idx;
    logic [31:0] jr;
    logic        link;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        retire;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic [25:0] jump_idx;
  logic [31:0] jr_target;
  logic        link_en;

  logic        imem_req, instr_valid, link_we, trap;
  logic [31:0] imem_addr, instr, link_addr, pc, epc;
  logic [1:0]  trap_cause;

  logic        nt_imem_req, nt_instr_valid, nt_link_we, nt_trap;
  logic [31:0] nt_imem_addr, nt_instr, nt_link_addr, nt_pc, nt_epc;
  logic [1:0]  nt_trap_cause;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pc_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80), .FETCH_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .retire(retire), .pc_sel(pc_sel), .branch_taken(branch_taken), .branch_off(branch_off),
    .jump_idx(jump_idx), .jr_target(jr_target), .link_en(link_en), .link_we(link_we),
    .link_addr(link_addr), .pc(pc), .trap(trap), .trap_cause(trap_cause), .epc(epc));

  pc_sequencer #(.ADDR_W(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80), .FETCH_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .imem_req(nt_imem_req), .imem_addr(nt_imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(nt_instr), .instr_valid(nt_instr_valid),
    .retire(retire), .pc_sel(pc_sel), .branch_taken(branch_taken), .branch_off(branch_off),
    .jump_idx(jump_idx), .jr_target(jr_target), .link_en(link_en), .link_we(nt_link_we),
    .link_addr(nt_link_addr), .pc(nt_pc), .trap(nt_trap), .trap_cause(nt_trap_cause), .epc(nt_epc));

  function automatic logic [31:0] next_pc(input logic [31:0] cur, input op_t op);
    logic [31:0] seq;
    seq = cur + 32'd4;
    case (op.sel)
      2'd0:    return seq;
      2'd1:    return op.taken ? seq + {{14{op.off[15]}}, op.off, 2'b00} : seq;
      2'd2:    return {seq[31:28], op.idx, 2'b00};
      default: return op.jr;
    endcase
  endfunction

  function automatic op_t mk(input logic [1:0] sel, input logic taken, input logic [15:0] off,
                             input logic [25:0] idx, input logic [31:0] jr, input logic link);
    op_t o;
    o.sel = sel; o.taken = taken; o.off = off; o.idx = idx; o.jr = jr; o.link = link;
    return o;
  endfunction

  // Starts at a negedge with the DUT in FETCH; ends at the negedge with it in EXEC.
  task automatic fetch_instr(input logic [31:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ready = 1'b0;
  endtask

  // Starts at a negedge with the DUT in EXEC; ends one cycle later.
  task automatic retire_op(input op_t op);
    retire = 1'b1; pc_sel = op.sel; branch_taken = op.taken; branch_off = op.off;
    jump_idx = op.idx; jr_target = op.jr; link_en = op.link;
    @(negedge clk);
    retire = 1'b0; link_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = '0; retire = 1'b0; pc_sel = '0;
    branch_taken = 1'b0; branch_off = '0; jump_idx = '0; jr_target = '0; link_en = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr got=%h/%b exp=0/0", instr, instr_valid); end
    checks++; if ({trap, link_we, trap_cause} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {trap, link_we, trap_cause}); end
    checks++; if (epc !== 32'h0 || link_addr !== 32'h0) begin failures++; $display("FAIL reset_regs got=%h/%h exp=0/0", epc, link_addr); end
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL reset_req got=%b/%h exp=1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] cur;
    op_t op;
    op = mk(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cur = exp_q.pop_front();
      checks++; if (imem_addr !== cur) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr, cur); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL seq_ivalid_lo%0d got=%b exp=0", i, instr_valid); end
      fetch_instr(32'hA000_0000 + i);
      checks++; if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 + i) begin failures++; $display("FAIL seq_instr%0d got=%b/%h exp=1/%h", i, instr_valid, instr, 32'hA000_0000 + i); end
      exp_q.push_back(next_pc(cur, op));
      retire_op(op);
    end
  endtask

  task automatic test_branch();
    op_t ops[$];
    logic [31:0] cur;
    ops = '{mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h40, 1'b0),
            mk(2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0),
            mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h40, 1'b0),
            mk(2'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b0),
            mk(2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0),
            mk(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0)};
    foreach (ops[i]) begin
      cur = exp_q.pop_front();
      checks++; if (imem_addr !== cur) begin failures++; $display("FAIL branch_addr%0d got=%h exp=%h", i, imem_addr, cur); end
      fetch_instr(32'hB000_0000 + i);
      exp_q.push_back(next_pc(cur, ops[i]));
      retire_op(ops[i]);
    end
  endtask

  task automatic test_jal();
    op_t ops[$];
    logic [31:0] cur;
    ops = '{mk(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0),
            mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h1000_0010, 1'b0),
            mk(2'd2, 1'b0, 16'h0, 26'h0000100, 32'h0, 1'b1)};
    foreach (ops[i]) begin
      cur = exp_q.pop_front();
      checks++; if (imem_addr !== cur) begin failures++; $display("FAIL jal_addr%0d got=%h exp=%h", i, imem_addr, cur); end
      checks++; if (link_we !== 1'b0) begin failures++; $display("FAIL jal_nolink%0d got=%b exp=0", i, link_we); end
      fetch_instr(32'h0C00_0000 + i);
      exp_q.push_back(next_pc(cur, ops[i]));
      retire_op(ops[i]);
    end
    checks++; if (link_we !== 1'b1 || link_addr !== 32'h1000_0014) begin failures++; $display("FAIL jal_link got=%b/%h exp=1/10000014", link_we, link_addr); end
    checks++; if (trap !== 1'b0) begin failures++; $display("FAIL jal_notrap got=%b exp=0", trap); end
    @(negedge clk);
    checks++; if (link_we !== 1'b0) begin failures++; $display("FAIL jal_link_once got=%b exp=0", link_we); end
  endtask

  task automatic test_misaligned_jr();
    op_t ops[$];
    op_t bad;
    logic [31:0] cur;
    cur = exp_q.pop_front();
    checks++; if (imem_addr !== cur) begin failures++; $display("FAIL mis_addr_a got=%h exp=%h", imem_addr, cur); end
    fetch_instr(32'h1);
    ops = '{mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h20, 1'b0)};
    exp_q.push_back(next_pc(cur, ops[0]));
    retire_op(ops[0]);
    cur = exp_q.pop_front();
    checks++; if (imem_addr !== cur) begin failures++; $display("FAIL mis_addr_b got=%h exp=%h", imem_addr, cur); end
    fetch_instr(32'h2);
    bad = mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h102, 1'b1);
    retire_op(bad);
    checks++; if (trap !== 1'b1 || link_we !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL mis_trap got=%b/%b/%b exp=1/0/0", trap, link_we, instr_valid); end
    @(negedge clk);
    checks++; if (trap !== 1'b0 || link_we !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b/%b exp=0/0", trap, link_we); end
    checks++; if (epc !== 32'h20 || trap_cause !== 2'b01) begin failures++; $display("FAIL mis_epc got=%h/%b exp=20/01", epc, trap_cause); end
    exp_q.push_back(32'h80);
    ops = '{mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h104, 1'b0),
            mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h8, 1'b0)};
    foreach (ops[i]) begin
      cur = exp_q.pop_front();
      checks++; if (imem_addr !== cur) begin failures++; $display("FAIL mis_addr%0d got=%h exp=%h", i, imem_addr, cur); end
      fetch_instr(32'h3 + i);
      exp_q.push_back(next_pc(cur, ops[i]));
      retire_op(ops[i]);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] cur;
    int k;
    int nt_traps;
    cur = exp_q.pop_front();
    checks++; if (imem_addr !== cur || nt_imem_addr !== cur) begin failures++; $display("FAIL to_addr got=%h/%h exp=%h", imem_addr, nt_imem_addr, cur); end
    imem_ready = 1'b0;
    k = 0; nt_traps = 0;
    while (trap !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
      if (nt_trap === 1'b1) nt_traps++;
    end
    checks++; if (trap !== 1'b1 || k != 4) begin failures++; $display("FAIL to_cycles got=%b/%0d exp=1/4", trap, k); end
    @(negedge clk);
    if (nt_trap === 1'b1) nt_traps++;
    checks++; if (epc !== 32'h8 || trap_cause !== 2'b10) begin failures++; $display("FAIL to_epc got=%h/%b exp=8/10", epc, trap_cause); end
    checks++; if (imem_addr !== 32'h80 || imem_req !== 1'b1 || trap !== 1'b0) begin failures++; $display("FAIL to_vector got=%h/%b/%b exp=80/1/0", imem_addr, imem_req, trap); end
    repeat (25) begin
      @(negedge clk);
      if (nt_trap === 1'b1) nt_traps++;
    end
    checks++; if (epc !== 32'h80 || trap_cause !== 2'b10) begin failures++; $display("FAIL to_repeat got=%h/%b exp=80/10", epc, trap_cause); end
    checks++; if (nt_traps != 0) begin failures++; $display("FAIL nt_notrap got=%0d exp=0", nt_traps); end
    checks++; if (nt_imem_addr !== 32'h8 || nt_imem_req !== 1'b1) begin failures++; $display("FAIL nt_wait got=%h/%b exp=8/1", nt_imem_addr, nt_imem_req); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] cur;
    op_t op;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    op = mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h40, 1'b0);
    cur = exp_q.pop_front();
    checks++; if (imem_addr !== cur) begin failures++; $display("FAIL mr_addr0 got=%h exp=%h", imem_addr, cur); end
    fetch_instr(32'h5);
    exp_q.push_back(next_pc(cur, op));
    retire_op(op);
    cur = exp_q.pop_front();
    checks++; if (imem_addr !== cur) begin failures++; $display("FAIL mr_addr1 got=%h exp=%h", imem_addr, cur); end
    fetch_instr(32'h6);
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h40) begin failures++; $display("FAIL mr_exec got=%b/%h exp=1/40", instr_valid, pc); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0 || instr_valid !== 1'b0 || instr !== 32'h0) begin failures++; $display("FAIL mr_exec_async got=%h/%b/%h exp=0/0/0", pc, instr_valid, instr); end
    checks++; if (epc !== 32'h0 || trap_cause !== 2'b00) begin failures++; $display("FAIL mr_trapregs got=%h/%b exp=0/00", epc, trap_cause); end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL mr_first_fetch got=%h/%b exp=0/1", imem_addr, imem_req); end
    fetch_instr(32'h7);
    retire_op(mk(2'd3, 1'b0, 16'h0, 26'h0, 32'h102, 1'b0));
    checks++; if (trap !== 1'b1) begin failures++; $display("FAIL mr_in_trap got=%b exp=1", trap); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (trap !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL mr_trap_async got=%b/%h/%b exp=0/0/1", trap, pc, imem_req); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0 || epc !== 32'h0 || trap !== 1'b0) begin failures++; $display("FAIL mr_after got=%h/%h/%b exp=0/0/0", imem_addr, epc, trap); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jal();
    test_misaligned_jr();
    test_timeout();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
